// File: rtl/datmem_arbiter.sv
// datmem_arbiter: shares a byte-wide big-endian data memory between a CPU
// word port and a debug/loader word port. Each granted word access becomes
// four byte beats on one synchronous 1R/W memory port.
//
// Optional build macro: DATMEM_ARB_CPU_PRIO_EN
//   defined   -> CPU wins every simultaneous request (no round-robin pointer)
//   undefined -> round-robin between the two ports
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU word request (held until cpu_ack)
//   cpu_ack, cpu_rdata             CPU completion pulse and read word
//   dbg_req/we/addr/wdata          debug word request (held until dbg_ack)
//   dbg_ack, dbg_rdata             debug completion pulse and read word
//   mem_en/we/addr/wdata           byte memory strobe, write enable, address, data
//   mem_rdata                      byte read data, valid the cycle after a read strobe
//   busy                           high whenever a transaction is in progress
module datmem_arbiter #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DRAIN, S_ACK} state_e;

    state_e              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic                own_q, own_d;       // 0 = CPU owns, 1 = debug owns
    logic                we_q, we_d;
    logic [23:0]         wsh_q, wsh_d;       // remaining write bytes, MSB first
    logic [23:0]         shift_q, shift_d;   // read bytes gathered so far
    logic                cap_q, cap_d;       // previous cycle was a read strobe
    logic                cpu_ack_q, cpu_ack_d;
    logic                dbg_ack_q, dbg_ack_d;
    logic [31:0]         cpu_rdata_q, cpu_rdata_d;
    logic [31:0]         dbg_rdata_q, dbg_rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;

    logic                gnt_dbg;
    logic                gnt_we;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [31:0]         gnt_wdata;

`ifndef DATMEM_ARB_CPU_PRIO_EN
    logic                pref_q, pref_d;     // 1 = debug wins the next tie
`endif

    // Grant selection for a request seen in IDLE
    always_comb begin
`ifdef DATMEM_ARB_CPU_PRIO_EN
        gnt_dbg   = dbg_req & ~cpu_req;
`else
        gnt_dbg   = dbg_req & (~cpu_req | pref_q);
`endif
        gnt_we    = gnt_dbg ? dbg_we    : cpu_we;
        gnt_addr  = gnt_dbg ? dbg_addr  : cpu_addr;
        gnt_wdata = gnt_dbg ? dbg_wdata : cpu_wdata;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        own_d       = own_q;
        we_d        = we_q;
        wsh_d       = wsh_q;
        cap_d       = mem_en_q & ~mem_we_q;
        shift_d     = cap_q ? {shift_q[15:0], mem_rdata} : shift_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = 8'h00;
`ifndef DATMEM_ARB_CPU_PRIO_EN
        pref_d      = pref_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req | dbg_req) begin
                    state_d     = S_BEAT;
                    k_d         = 2'd0;
                    own_d       = gnt_dbg;
                    we_d        = gnt_we;
                    wsh_d       = gnt_wdata[23:0];
                    mem_en_d    = 1'b1;
                    mem_we_d    = gnt_we;
                    mem_addr_d  = gnt_addr;
                    mem_wdata_d = gnt_wdata[31:24];
`ifndef DATMEM_ARB_CPU_PRIO_EN
                    pref_d      = ~gnt_dbg;
`endif
                end
            end
            S_BEAT: begin
                if (k_q == 2'd3) begin
                    if (we_q) begin
                        state_d   = S_ACK;
                        cpu_ack_d = ~own_q;
                        dbg_ack_d = own_q;
                    end else begin
                        state_d   = S_DRAIN;
                    end
                end else begin
                    // Address increments in ADDR_W bits, so it wraps naturally
                    k_d         = k_q + 2'd1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_q;
                    mem_addr_d  = mem_addr_q + ADDR_W'(1);
                    mem_wdata_d = wsh_q[23:16];
                    wsh_d       = {wsh_q[15:0], 8'h00};
                end
            end
            S_DRAIN: begin
                // Last byte arrives this cycle; complete the word directly
                state_d   = S_ACK;
                cpu_ack_d = ~own_q;
                dbg_ack_d = own_q;
                if (own_q) begin
                    dbg_rdata_d = {shift_q, mem_rdata};
                end else begin
                    cpu_rdata_d = {shift_q, mem_rdata};
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= 2'd0;
            own_q       <= 1'b0;
            we_q        <= 1'b0;
            wsh_q       <= '0;
            shift_q     <= '0;
            cap_q       <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
`ifndef DATMEM_ARB_CPU_PRIO_EN
            pref_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            own_q       <= own_d;
            we_q        <= we_d;
            wsh_q       <= wsh_d;
            shift_q     <= shift_d;
            cap_q       <= cap_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
`ifndef DATMEM_ARB_CPU_PRIO_EN
            pref_q      <= pref_d;
`endif
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_datmem_arbiter.sv
// Testbench for datmem_arbiter: a transaction-level model predicts every
// output each cycle from the grant cycle and the beat schedule, plus directed
// literal checks on memory contents, read words, latency and grant order.
// Honours DATMEM_ARB_CPU_PRIO_EN when the same macro is given to the build.
module tb_datmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [5:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [5:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;

    datmem_arbiter #(.ADDR_W(6)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Byte RAM the DUT drives
    logic [7:0] ram [64];
    initial for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level reference model
    logic [7:0]  shadow [64];
    initial for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
    bit          chk_on = 0;
    int          cyc = 0;
    bit          m_act = 0, m_owner = 0, m_we = 0, m_pref = 0;
    int          m_start = 0;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata, m_rword;
    bit          e_en = 0, e_we = 0, e_busy = 0, e_cack = 0, e_dack = 0;
    logic [5:0]  e_addr = '0;
    logic [7:0]  e_wd = '0;
    logic [31:0] e_crd = '0, e_drd = '0;
    int          ack_order[$];

    always @(negedge clk) begin
        int d;
        if (chk_on) begin
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("cpu_ack", 32'(cpu_ack), 32'(e_cack));
            chk("dbg_ack", 32'(dbg_ack), 32'(e_dack));
            chk("cpu_rdata", cpu_rdata, e_crd);
            chk("dbg_rdata", dbg_rdata, e_drd);
            if (e_en) begin
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            end
        end
        if (cpu_ack) ack_order.push_back(0);
        if (dbg_ack) ack_order.push_back(1);
        // Advance: decide what cycle cyc+1 must look like
        e_en = 0; e_we = 0; e_cack = 0; e_dack = 0; e_busy = 0;
        if (rst) begin
            m_act = 0; m_pref = 0; e_crd = '0; e_drd = '0; chk_on = 1;
        end else begin
            if (m_act && cyc == m_start + (m_we ? 5 : 6)) begin
                m_act = 0;
            end else if (!m_act && (cpu_req || dbg_req)) begin
`ifdef DATMEM_ARB_CPU_PRIO_EN
                m_owner = !cpu_req;
`else
                m_owner = (cpu_req && dbg_req) ? m_pref : !cpu_req;
                m_pref  = !m_owner;
`endif
                m_act   = 1;
                m_start = cyc;
                m_we    = m_owner ? dbg_we : cpu_we;
                m_addr  = m_owner ? dbg_addr : cpu_addr;
                m_wdata = m_owner ? dbg_wdata : cpu_wdata;
                m_rword = '0;
            end
            if (m_act) begin
                d = cyc + 1 - m_start;
                e_busy = 1;
                if (d >= 1 && d <= 4) begin
                    e_en   = 1;
                    e_we   = m_we;
                    e_addr = 6'((int'(m_addr) + d - 1) % 64);
                    e_wd   = 8'(m_wdata >> (8 * (4 - d)));
                    if (m_we) shadow[e_addr] = e_wd;
                    else m_rword = {m_rword[23:0], shadow[e_addr]};
                end
                if (d == (m_we ? 5 : 6)) begin
                    if (m_owner) e_dack = 1; else e_cack = 1;
                    if (!m_we) begin
                        if (m_owner) e_drd = m_rword; else e_crd = m_rword;
                    end
                end
            end
        end
        cyc++;
    end

    // Requester: raise req, wait for ack (bounded), drop req the next cycle
    task automatic run_port(input bit dbg, input bit we, input logic [5:0] a,
                            input logic [31:0] wd, output int lat, output logic [31:0] rd);
        @(posedge clk); #1;
        if (dbg) begin dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1; end
        else begin cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1; end
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (dbg ? dbg_ack : cpu_ack) break;
            if (lat > 60) begin
                n_total++;
                $display("FAIL ack_timeout port=%0d: got no ack required ack within 60 cycles", dbg);
                break;
            end
        end
        rd = dbg ? dbg_rdata : cpu_rdata;
        @(posedge clk); #1;
        if (dbg) dbg_req = 0; else cpu_req = 0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
    endtask

    task automatic rand_port(input bit dbg, input int n);
        int lat;
        logic [31:0] rd;
        for (int i = 0; i < n; i++) begin
            run_port(dbg, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, lat, rd);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    initial begin
        int lat, lat2;
        logic [31:0] rd, rd2;
        int exp_order[$];

        // Reset with random inputs
        cpu_req = 1'($urandom_range(0, 1)); dbg_req = 1'($urandom_range(0, 1));
        cpu_we = 1; dbg_we = 1; cpu_wdata = $urandom; dbg_wdata = $urandom;
        repeat (2) @(posedge clk);
        #1;
        rst = 0; cpu_req = 0; dbg_req = 0;
        repeat (2) @(posedge clk);

        // CPU write DEADBEEF at 8
        run_port(0, 1, 6'd8, 32'hDEADBEEF, lat, rd);
        chk("cpu_wr_latency", 32'(lat), 32'd5);
        chk("ram8", 32'(ram[8]), 32'hDE);
        chk("ram9", 32'(ram[9]), 32'hAD);
        chk("ram10", 32'(ram[10]), 32'hBE);
        chk("ram11", 32'(ram[11]), 32'hEF);

        // Debug read back
        run_port(1, 0, 6'd8, 32'h0, lat, rd);
        chk("dbg_rd_latency", 32'(lat), 32'd6);
        chk("dbg_rdata_deadbeef", rd, 32'hDEADBEEF);
        chk("cpu_rdata_untouched", cpu_rdata, 32'h0);

        // Wrap-around write and readback
        run_port(0, 1, 6'd62, 32'h11223344, lat, rd);
        chk("ram62", 32'(ram[62]), 32'h11);
        chk("ram63", 32'(ram[63]), 32'h22);
        chk("ram0", 32'(ram[0]), 32'h33);
        chk("ram1", 32'(ram[1]), 32'h44);
        run_port(0, 0, 6'd62, 32'h0, lat, rd);
        chk("wrap_readback", rd, 32'h11223344);

        // Simultaneous requests after reset
        pulse_rst();
        #1;
        chk("dbg_rdata_cleared", dbg_rdata, 32'h0);
        chk("cpu_rdata_cleared", cpu_rdata, 32'h0);
        ack_order.delete();
        fork
            run_port(0, 1, 6'd20, 32'hA0A1A2A3, lat, rd);
            run_port(1, 1, 6'd24, 32'hB0B1B2B3, lat2, rd2);
        join
        run_port(0, 1, 6'd28, 32'hC0C1C2C3, lat, rd);
        fork
            run_port(0, 1, 6'd32, 32'hD0D1D2D3, lat, rd);
            run_port(1, 1, 6'd36, 32'hE0E1E2E3, lat2, rd2);
        join
`ifdef DATMEM_ARB_CPU_PRIO_EN
        exp_order = '{0, 1, 0, 0, 1};
`else
        exp_order = '{0, 1, 0, 1, 0};
`endif
        chk("order_len", 32'(ack_order.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("order%0d", i), 32'(ack_order.size() > i ? ack_order[i] : 9), 32'(exp_order[i]));
        chk("ram20", 32'(ram[20]), 32'hA0);
        chk("ram39", 32'(ram[39]), 32'hE3);

        // Reset during the second beat of a write
        @(posedge clk); #1;
        cpu_we = 1; cpu_addr = 6'd0; cpu_wdata = 32'hAABBCCDD; cpu_req = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_beat_addr", 32'(mem_addr), 32'd1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; cpu_req = 0;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (8) begin
            @(posedge clk); #1;
            chk("abort_no_ack", 32'(cpu_ack), 32'd0);
        end
        chk("abort_ram0", 32'(ram[0]), 32'hAA);
        chk("abort_ram1", 32'(ram[1]), 32'hBB);
        chk("abort_ram2", 32'(ram[2]), 32'h00);
        run_port(0, 1, 6'd2, 32'h01020304, lat, rd);
        chk("post_abort_latency", 32'(lat), 32'd5);
        chk("post_abort_ram5", 32'(ram[5]), 32'h04);

        // Random concurrent traffic
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/datmem_arbiter.md
Name: datmem_arbiter

Overview:
- Shares the 64-byte, byte-wide, big-endian data memory between two 32-bit word requesters: the CPU load/store port and a debug/loader port.
- Each granted word access is broken into four sequential byte beats on a single memory port.
- A word is assembled or split big-endian: byte at address A holds bits 31:24, byte at A+3 holds bits 7:0.
- Sits between the processor datapath and the datmem byte array; the array becomes a plain synchronous 1R/W byte RAM.

Parameters:
- ADDR_W, 6, byte address width; memory depth is 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU word access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  ADDR_W  byte address of word MSB; stable while cpu_req.
- cpu_wdata  in  32  write word; stable while cpu_req.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read word; valid when cpu_ack is high, held until the next CPU read completes.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as the cpu_* set, for the debug port.
- mem_en  out  1  byte access strobe.
- mem_we  out  1  byte write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; valid in the cycle after a read strobe.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs 0 (acks, rdata, mem_*, busy). State goes to IDLE, beat counter to 0, round-robin pointer to CPU.
- States:
  - IDLE: sample requests; on grant, latch we/addr/wdata and the owner, then go to BEAT.
  - BEAT: issue the beat given by counter k = 0..3.
    - mem_en=1, mem_we=latched we, mem_addr = addr+k mod 2^ADDR_W, mem_wdata = wdata[31-8k -: 8].
    - After k=3: a write goes to ACK; a read goes to DRAIN.
  - DRAIN (reads only): capture the last byte.
  - ACK: pulse the owner's ack for one cycle, then go to IDLE.
- Read capture: the byte for beat k is sampled from mem_rdata in the cycle after beat k issues and written into an internal shift register. The owner's rdata register is updated on entry to ACK.
- Latency, with the grant in cycle T:
  - Beats occur in cycles T+1..T+4.
  - Write ack in T+5.
  - Read ack in T+6.
  - Requests are never granted back-to-back without passing through IDLE.
- Handshake: the requester must drop req in the cycle after ack; a req still high in IDLE starts a new transaction. Request fields are sampled only at grant; later changes are ignored.
- Arbitration in IDLE:
  - Single request: granted.
  - Both requesting: the port not granted last wins; the pointer updates on each grant.
- The non-owner's ack and rdata are untouched during a transaction.
- Address wrap: beat addresses wrap modulo 2^ADDR_W (e.g., addr 62 gives bytes 62, 63, 0, 1). No alignment check.
- mem_en is 0 in IDLE, DRAIN and ACK.
- Reset mid-transaction:
  - Abort and return to IDLE next cycle, with mem_en=0 next cycle and no ack.
  - Bytes already written stay written; rdata registers clear to 0.
  - A req arriving in the same cycle as rst is ignored.

Optional Feature:
- Macro: DATMEM_ARB_CPU_PRIO_EN.
- Defined: fixed priority; the CPU wins every simultaneous request and the round-robin pointer is removed.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset check: assert rst for 2 cycles with random inputs -> all outputs 0, busy=0, no mem_en.
- CPU write: cpu_addr=8, cpu_wdata=0xDEADBEEF, grant at T -> mem writes DE@8, AD@9, BE@10, EF@11 in T+1..T+4; cpu_ack pulse at T+5; dbg_ack stays 0.
- Debug read: dbg read of addr 8 after the previous write -> four reads at addr 8..11; dbg_ack at T+6 with dbg_rdata=0xDEADBEEF; cpu_rdata unchanged.
- Wrap-around: CPU write 0x11223344 at addr 62 -> bytes 11@62, 22@63, 33@0, 44@1; a readback returns 0x11223344.
- Simultaneous requests, twice after reset, both ports writing:
  - Default build: order CPU, DBG, then DBG, CPU.
  - With DATMEM_ARB_CPU_PRIO_EN: CPU first both times.
- Reset during write: rst in the cycle of beat 2 of a write of 0xAABBCCDD at addr 0 -> only AA@0 and BB@1 written; no ack; mem_en=0 next cycle; a following CPU request completes normally.
